// File: rtl/ddr2_pkg.sv
// Shared definitions for the ddr2 host-side blocks.
//   - command encodings driven on the controller CMD port
//   - read-owner tag layout {owner, beat count}
//   - burst_len(): words moved by a block command, 8*(SZ+1)
package ddr2_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 6;   // holds 1..32 beats

    typedef enum logic [2:0] {
        NOP0 = 3'b000,
        SCR  = 3'b001,
        SCW  = 3'b010,
        BLR  = 3'b011,
        BLW  = 3'b100,
        ATR  = 3'b101,
        ATW  = 3'b110,
        NOP7 = 3'b111
    } cmd_e;

    typedef enum logic {
        ST_IDLE,
        ST_BLKW
    } state_e;

    // One entry per outstanding read: who asked, and how many VALIDOUT beats it owns.
    typedef struct packed {
        logic             owner;
        logic [CNT_W-1:0] count;
    } tag_t;

    function automatic logic [CNT_W-1:0] burst_len(input logic [1:0] sz);
        return {1'b0, sz, 3'b000} + 6'd8;
    endfunction

endpackage

// File: rtl/ddr2_tag_fifo.sv
// In-order FIFO of read-owner tags.
//   clk, reset   : clock, synchronous active-high reset
//   push, wdata  : enqueue (ignored when full)
//   pop          : dequeue head (ignored when empty); push and pop may coincide
//   rdata        : current head entry (valid when !empty)
//   full, empty  : occupancy flags
module ddr2_tag_fifo
    import ddr2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  tag_t wdata,
    input  logic pop,
    output tag_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    tag_t        mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)  wptr <= wptr + PTR_ONE;
            if (pop  && !empty) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ddr2_host_arbiter.sv
// Two-requester front end for the ddr2_controller host command port.
//   R0_*/R1_*  : requester command/data inputs, READY (accept) and VALIDOUT
//                (read data for this requester) outputs, FETCHING inputs
//   CMD..DIN   : command/data to the controller; only driven non-NOP when the
//                controller can consume it this cycle
//   FETCHING   : read-data backpressure forwarded from the owner of the
//                oldest outstanding read
//   FILLCOUNT, NOTFULL, VALIDOUT : controller status
//   RSP_ERR    : sticky, read data arrived with no outstanding read
module ddr2_host_arbiter
    import ddr2_pkg::*;
#(
    parameter int TAG_DEPTH  = 8,
    parameter int FILL_LIMIT = 63
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              R0_VALID,
    input  logic [2:0]        R0_CMD,
    input  logic [1:0]        R0_SZ,
    input  logic [2:0]        R0_OP,
    input  logic [ADDR_W-1:0] R0_ADDR,
    input  logic [DATA_W-1:0] R0_DIN,
    output logic              R0_READY,
    input  logic              R0_FETCHING,
    output logic              R0_VALIDOUT,
    input  logic              R1_VALID,
    input  logic [2:0]        R1_CMD,
    input  logic [1:0]        R1_SZ,
    input  logic [2:0]        R1_OP,
    input  logic [ADDR_W-1:0] R1_ADDR,
    input  logic [DATA_W-1:0] R1_DIN,
    output logic              R1_READY,
    input  logic              R1_FETCHING,
    output logic              R1_VALIDOUT,
    output logic [2:0]        CMD,
    output logic [1:0]        SZ,
    output logic [2:0]        OP,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DIN,
    output logic              FETCHING,
    input  logic [6:0]        FILLCOUNT,
    input  logic              NOTFULL,
    input  logic              VALIDOUT,
    output logic              RSP_ERR
);

    localparam logic [6:0] FILL_LIM = 7'(FILL_LIMIT);

    state_e           state, state_nx;
    logic             ptr;        // round-robin preference, 0 = R0
    logic             owner;      // requester holding the block-write burst
    logic [CNT_W-1:0] beat_cnt;   // data beats still owed by the burst
    logic [CNT_W-1:0] rsp_cnt;    // beats left on the head read, once loaded
    logic             rsp_loaded;

    // Candidate selection and its fields
    logic              cand;
    logic [2:0]        c_cmd;
    logic [1:0]        c_sz;
    logic [2:0]        c_op;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_din;
    logic              own_valid;
    logic [DATA_W-1:0] own_din;

    logic fill_ok, can_issue, is_nop;
    logic idle_go, fwd, beat_go, last_beat;

    tag_t             tag_wdata, head;
    logic             tag_push, tag_pop, tag_full, tag_empty;
    logic [CNT_W-1:0] head_left;
    logic             rsp_hit;

    always_comb begin
        cand   = (R0_VALID && R1_VALID) ? ptr : R1_VALID;
        c_cmd  = cand ? R1_CMD  : R0_CMD;
        c_sz   = cand ? R1_SZ   : R0_SZ;
        c_op   = cand ? R1_OP   : R0_OP;
        c_addr = cand ? R1_ADDR : R0_ADDR;
        c_din  = cand ? R1_DIN  : R0_DIN;
        own_valid = owner ? R1_VALID : R0_VALID;
        own_din   = owner ? R1_DIN   : R0_DIN;
    end

    assign fill_ok = (FILLCOUNT <= FILL_LIM);

    // Reads need a free tag; anything carrying write data needs FIFO space.
    // ATR is both, since it writes and returns a value.
    always_comb begin
        can_issue = 1'b0;
        is_nop    = 1'b0;
        case (c_cmd)
            SCR, BLR:      can_issue = NOTFULL && !tag_full;
            SCW, BLW, ATW: can_issue = NOTFULL && fill_ok;
            ATR:           can_issue = NOTFULL && fill_ok && !tag_full;
            default: begin
                can_issue = 1'b1;
                is_nop    = 1'b1;
            end
        endcase
    end

    assign idle_go   = !RESET && (state == ST_IDLE) && (R0_VALID || R1_VALID) && can_issue;
    assign fwd       = idle_go && !is_nop;
    assign beat_go   = !RESET && (state == ST_BLKW) && own_valid && fill_ok;
    assign last_beat = beat_go && (beat_cnt == 6'd1);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (fwd && c_cmd == BLW) state_nx = ST_BLKW;
            ST_BLKW: if (last_beat)           state_nx = ST_IDLE;
            default:                          state_nx = ST_IDLE;
        endcase
    end

    // Outputs: nothing is presented to the controller unless it is consumed now.
    always_comb begin
        CMD      = '0;
        SZ       = '0;
        OP       = '0;
        ADDR     = '0;
        DIN      = '0;
        R0_READY = 1'b0;
        R1_READY = 1'b0;
        case (state)
            ST_IDLE: if (idle_go) begin
                R0_READY = !cand;
                R1_READY = cand;
                if (!is_nop) begin
                    CMD  = c_cmd;
                    SZ   = c_sz;
                    OP   = c_op;
                    ADDR = c_addr;
                    DIN  = c_din;
                end
            end
            ST_BLKW: if (beat_go) begin
                R0_READY = !owner;
                R1_READY = owner;
                DIN      = own_din;
            end
            default: ;
        endcase
    end

    // Arbitration pointer and burst bookkeeping. The BLW command itself
    // carries word 1, so the burst owes burst_len-1 further beats.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr      <= 1'b0;
            owner    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (fwd) begin
                if (c_cmd == BLW) begin
                    owner    <= cand;
                    beat_cnt <= burst_len(c_sz) - 6'd1;
                end else begin
                    ptr <= ~ptr;
                end
            end
            if (beat_go) begin
                beat_cnt <= beat_cnt - 6'd1;
                if (beat_cnt == 6'd1) ptr <= ~ptr;
            end
        end
    end

    // Read-owner tags
    assign tag_push        = fwd && (c_cmd == SCR || c_cmd == BLR || c_cmd == ATR);
    assign tag_wdata.owner = cand;
    assign tag_wdata.count = (c_cmd == BLR) ? burst_len(c_sz) : 6'd1;

    ddr2_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (CLK),
        .reset (RESET),
        .push  (tag_push),
        .wdata (tag_wdata),
        .pop   (tag_pop),
        .rdata (head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Until the first beat of a read lands, the remaining count comes straight
    // from the head tag; afterwards the local counter tracks it.
    assign head_left = rsp_loaded ? rsp_cnt : head.count;
    assign rsp_hit   = !RESET && VALIDOUT && !tag_empty;
    assign tag_pop   = rsp_hit && (head_left == 6'd1);

    assign R0_VALIDOUT = rsp_hit && !head.owner;
    assign R1_VALIDOUT = rsp_hit &&  head.owner;
    assign FETCHING    = (RESET || tag_empty) ? 1'b1 :
                         (head.owner ? R1_FETCHING : R0_FETCHING);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rsp_cnt    <= '0;
            rsp_loaded <= 1'b0;
            RSP_ERR    <= 1'b0;
        end else begin
            if (rsp_hit) begin
                if (head_left == 6'd1) begin
                    rsp_loaded <= 1'b0;
                end else begin
                    rsp_cnt    <= head_left - 6'd1;
                    rsp_loaded <= 1'b1;
                end
            end
            if (VALIDOUT && tag_empty) RSP_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr2_host_arbiter.sv
// Bench for ddr2_host_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model (queue of pending reads,
// burst beats owed, round-robin preference).
module tb_ddr2_host_arbiter;

    localparam int TD = 8;
    localparam int FL = 63;

    logic        CLK = 1'b0;
    logic        rst;
    logic        v     [2];
    logic [2:0]  cmd   [2];
    logic [1:0]  sz    [2];
    logic [2:0]  op    [2];
    logic [24:0] addr  [2];
    logic [15:0] din   [2];
    logic        fetch [2];
    logic [6:0]  fill;
    logic        notfull, validout;

    logic        R0_READY, R1_READY, R0_VALIDOUT, R1_VALIDOUT;
    logic [2:0]  CMD, OP;
    logic [1:0]  SZ;
    logic [24:0] ADDR;
    logic [15:0] DIN;
    logic        FETCHING, RSP_ERR;

    always #5 CLK = ~CLK;

    ddr2_host_arbiter #(.TAG_DEPTH(TD), .FILL_LIMIT(FL)) dut (
        .CLK(CLK), .RESET(rst),
        .R0_VALID(v[0]), .R0_CMD(cmd[0]), .R0_SZ(sz[0]), .R0_OP(op[0]), .R0_ADDR(addr[0]),
        .R0_DIN(din[0]), .R0_READY(R0_READY), .R0_FETCHING(fetch[0]), .R0_VALIDOUT(R0_VALIDOUT),
        .R1_VALID(v[1]), .R1_CMD(cmd[1]), .R1_SZ(sz[1]), .R1_OP(op[1]), .R1_ADDR(addr[1]),
        .R1_DIN(din[1]), .R1_READY(R1_READY), .R1_FETCHING(fetch[1]), .R1_VALIDOUT(R1_VALIDOUT),
        .CMD(CMD), .SZ(SZ), .OP(OP), .ADDR(ADDR), .DIN(DIN), .FETCHING(FETCHING),
        .FILLCOUNT(fill), .NOTFULL(notfull), .VALIDOUT(validout), .RSP_ERR(RSP_ERR)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int owner; int left; } rd_t;
    rd_t q[$];
    bit  m_burst, m_ptr, m_err;
    int  m_own, m_left;

    // expected outputs / decisions for the current cycle
    logic [2:0]  e_cmd, e_op;
    logic [1:0]  e_sz;
    logic [24:0] e_addr;
    logic [15:0] e_din;
    bit          e_rdy [2];
    bit          e_vo  [2];
    bit          e_fetch, e_fwd, e_beat;
    int          e_cand;

    // observations kept for scenario-level checks
    logic [2:0] obs_cmd;
    logic       obs_rdy1, obs_err;
    int         n_rdy [2];
    int         n_vo  [2];

    task automatic model_comb();
        int  c;
        bit  ok;
        e_cmd = 0; e_sz = 0; e_op = 0; e_addr = 0; e_din = 0;
        e_rdy[0] = 0; e_rdy[1] = 0; e_vo[0] = 0; e_vo[1] = 0;
        e_fetch = 1; e_fwd = 0; e_beat = 0; e_cand = 0;
        if (rst) return;
        if (m_burst) begin
            if (v[m_own] && fill <= FL) begin
                e_beat = 1; e_rdy[m_own] = 1; e_din = din[m_own];
            end
        end else if (v[0] || v[1]) begin
            c = (v[0] && v[1]) ? int'(m_ptr) : (v[1] ? 1 : 0);
            e_cand = c;
            case (cmd[c])
                3'd1, 3'd3: ok = notfull && q.size() < TD;
                3'd5:       ok = notfull && fill <= FL && q.size() < TD;
                3'd2, 3'd4, 3'd6: ok = notfull && fill <= FL;
                default:    ok = 1;
            endcase
            if (ok) begin
                e_rdy[c] = 1;
                if (cmd[c] != 3'd0 && cmd[c] != 3'd7) begin
                    e_fwd = 1; e_cmd = cmd[c]; e_sz = sz[c]; e_op = op[c];
                    e_addr = addr[c]; e_din = din[c];
                end
            end
        end
        if (q.size() > 0) begin
            e_fetch = fetch[q[0].owner];
            e_vo[q[0].owner] = validout;
        end
    endtask

    task automatic model_seq();
        rd_t h;
        if (rst) begin
            q.delete(); m_burst = 0; m_ptr = 0; m_err = 0; m_own = 0; m_left = 0;
            return;
        end
        if (validout) begin
            if (q.size() == 0) m_err = 1;
            else begin
                h = q[0]; h.left--;
                if (h.left == 0) void'(q.pop_front());
                else q[0] = h;
            end
        end
        if (e_fwd) begin
            if (e_cmd == 3'd1 || e_cmd == 3'd5) q.push_back('{e_cand, 1});
            if (e_cmd == 3'd3) q.push_back('{e_cand, 8 * (int'(e_sz) + 1)});
            if (e_cmd == 3'd4) begin
                m_burst = 1; m_own = e_cand; m_left = 8 * (int'(e_sz) + 1) - 1;
            end else m_ptr = ~m_ptr;
        end
        if (e_beat) begin
            m_left--;
            if (m_left == 0) begin m_burst = 0; m_ptr = ~m_ptr; end
        end
    endtask

    // One clock: compare at the falling edge, advance model at the rising edge.
    task automatic step();
        @(negedge CLK);
        model_comb();
        chk("cmd",   CMD,  e_cmd);
        chk("sz",    SZ,   e_sz);
        chk("op",    OP,   e_op);
        chk("addr",  ADDR, e_addr);
        chk("din",   DIN,  e_din);
        chk("rdy0",  R0_READY, e_rdy[0]);
        chk("rdy1",  R1_READY, e_rdy[1]);
        chk("vo0",   R0_VALIDOUT, e_vo[0]);
        chk("vo1",   R1_VALIDOUT, e_vo[1]);
        chk("fetch", FETCHING, e_fetch);
        chk("err",   RSP_ERR, m_err);
        obs_cmd = CMD; obs_rdy1 = R1_READY; obs_err = RSP_ERR;
        n_rdy[0] += int'(R0_READY); n_rdy[1] += int'(R1_READY);
        n_vo[0]  += int'(R0_VALIDOUT); n_vo[1] += int'(R1_VALIDOUT);
        @(posedge CLK);
        model_seq();
        #1;
    endtask

    task automatic quiet();
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; cmd[i] = 0; sz[i] = 0; op[i] = 0; addr[i] = 0; din[i] = 0; fetch[i] = 1;
        end
        fill = 7'd10; notfull = 1; validout = 0;
    endtask

    task automatic clr_counts();
        n_rdy[0] = 0; n_rdy[1] = 0; n_vo[0] = 0; n_vo[1] = 0;
    endtask

    initial begin
        quiet();
        rst = 1;
        m_burst = 0; m_ptr = 0; m_err = 0; m_own = 0; m_left = 0;
        step(); step();
        rst = 0;
        step();

        // Both SCW: R0 first, then R1
        v[0] = 1; v[1] = 1; cmd[0] = 3'd2; cmd[1] = 3'd2;
        addr[0] = 25'h0000123; addr[1] = 25'h1abcdef; din[0] = 16'h1111; din[1] = 16'h2222;
        clr_counts();
        step(); step();
        chk("scw_both_r0", n_rdy[0], 1);
        chk("scw_both_r1", n_rdy[1], 1);
        quiet();

        // BLW SZ=1 with a fill stall; R1 SCR waits for the burst
        v[0] = 1; cmd[0] = 3'd4; sz[0] = 2'd1; addr[0] = 25'h40; din[0] = 16'hb000;
        v[1] = 1; cmd[1] = 3'd1; addr[1] = 25'h99;
        step();
        clr_counts();
        for (int i = 0; i < 40 && m_burst; i++) begin
            fill = (i >= 4 && i < 7) ? 7'd64 : 7'd10;
            din[0] = 16'(16'hb001 + i);
            step();
        end
        chk("blw_beats", n_rdy[0], 15);
        chk("blw_r1_held", n_rdy[1], 0);
        fill = 7'd10; v[0] = 0;
        step();
        chk("scr_after_burst", obs_cmd, 3'd1);
        v[1] = 0; validout = 1;
        step();
        validout = 0;

        // BLR SZ=0 from R0 then SCR from R1; responses route 8 then 1
        v[0] = 1; cmd[0] = 3'd3; sz[0] = 2'd0; addr[0] = 25'h800;
        v[1] = 1; cmd[1] = 3'd1; addr[1] = 25'h900;
        step();
        v[0] = 0;
        step();
        v[1] = 0; validout = 1; clr_counts();
        for (int i = 0; i < 9; i++) begin
            fetch[0] = 1'($urandom); fetch[1] = 1'($urandom);
            step();
        end
        validout = 0; fetch[0] = 1; fetch[1] = 1;
        chk("blr_vo0", n_vo[0], 8);
        chk("blr_vo1", n_vo[1], 1);

        // Tag FIFO full holds off the 9th read until one completes
        v[0] = 1; cmd[0] = 3'd1;
        for (int i = 0; i < TD; i++) begin addr[0] = 25'(i); step(); end
        step();
        chk("tagfull_hold", obs_cmd, 3'd0);
        validout = 1;
        step();
        chk("tagfull_pop_cycle", obs_cmd, 3'd0);
        validout = 0;
        step();
        chk("tagfull_resume", obs_cmd, 3'd1);
        v[0] = 0; validout = 1;
        for (int i = 0; i < TD; i++) step();
        validout = 0;

        // NOTFULL low blocks R1 SCW; issues in the cycle it rises
        notfull = 0; v[1] = 1; cmd[1] = 3'd2; addr[1] = 25'h555;
        step();
        chk("nf_block_cmd", obs_cmd, 3'd0);
        chk("nf_block_rdy", obs_rdy1, 1'b0);
        notfull = 1;
        step();
        chk("nf_issue_cmd", obs_cmd, 3'd2);
        chk("nf_issue_rdy", obs_rdy1, 1'b1);
        v[1] = 0;

        // Reset in the middle of a burst, then stray read data
        v[0] = 1; cmd[0] = 3'd4; sz[0] = 2'd3;
        step(); step(); step(); step();
        rst = 1; v[0] = 0;
        step();
        rst = 0;
        step();
        chk("rst_burst_idle", obs_cmd, 3'd0);
        validout = 1;
        step();
        validout = 0;
        step();
        chk("stray_rsp_err", obs_err, 1'b1);

        // Random traffic
        rst = 1; step(); rst = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                v[i]     = ($urandom_range(0, 3) != 0);
                cmd[i]   = 3'($urandom_range(0, 7));
                sz[i]    = 2'($urandom);
                op[i]    = 3'($urandom);
                addr[i]  = 25'($urandom);
                din[i]   = 16'($urandom);
                fetch[i] = 1'($urandom);
            end
            notfull  = ($urandom_range(0, 7) != 0);
            fill     = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(60, 127)) : 7'($urandom_range(0, 59));
            validout = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 299) == 0);
            rst      = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
